// File: rtl/picosoc_regs_pkg.sv
// rtl/picosoc_regs_pkg.sv - shared widths, state enum and load-queue entry type for the write-back stage
package picosoc_regs_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  typedef enum logic {
    INIT,
    RUN
  } wb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } lq_entry_t;

endpackage

// File: rtl/picosoc_wb_fifo.sv
// rtl/picosoc_wb_fifo.sv - load-result FIFO with per-entry valid bits and a parallel destination compare
module picosoc_wb_fifo
  import picosoc_regs_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  lq_entry_t        push_entry,
  input  logic             pop,
  output lq_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  input  logic [4:0]       cmp_addr,
  output logic             hit
);

  lq_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Push only happens when not full and pop only when not empty, so the two never hit the same slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (mem[i].addr[4:0] == cmp_addr) && (cmp_addr != 5'd0)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/picosoc_regs_wb.sv
// rtl/picosoc_regs_wb.sv - register-file write-back: post-reset clear sweep, ALU/load arbitration, load hazard lookup
module picosoc_regs_wb #(
  parameter int DATA_W       = picosoc_regs_pkg::DATA_W,
  parameter int ADDR_W       = picosoc_regs_pkg::ADDR_W,
  parameter int LQ_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] hz_addr,
  output logic              hz_pending,
  output logic              init_busy,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);

  import picosoc_regs_pkg::*;

  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
  localparam int CNT_W = $clog2(LQ_DEPTH + 1);

  wb_state_t        state;
  wb_state_t        state_nxt;
  logic [4:0]       sweep_cnt;
  logic [ST_W-1:0]  starve_cnt;
  lq_entry_t        lq_in;
  lq_entry_t        lq_head;
  logic [CNT_W-1:0] lq_count;
  logic             lq_full;
  logic             lq_empty;
  logic             lq_hit;
  logic             run;
  logic             alu_wr;
  logic             lq_push;
  logic             lq_pop;

  assign run        = (state == RUN);
  assign alu_ready  = run && (starve_cnt != ST_W'(STARVE_LIMIT));
  assign ld_ready   = run && !lq_full;
  assign init_busy  = !run;
  assign hz_pending = !run || lq_hit;

  // x0 writes are swallowed at the handshake so they never steal a write-port slot.
  assign alu_wr  = alu_valid && alu_ready && (alu_addr[4:0] != 5'd0);
  assign lq_push = ld_valid && ld_ready && (ld_addr[4:0] != 5'd0);
  assign lq_pop  = run && !lq_empty && !alu_wr;
  assign lq_in   = '{addr: ld_addr, data: ld_data};

  picosoc_wb_fifo #(
    .DEPTH(LQ_DEPTH)
  ) u_lq (
    .clk       (clk),
    .reset     (reset),
    .push      (lq_push),
    .push_entry(lq_in),
    .pop       (lq_pop),
    .head      (lq_head),
    .count     (lq_count),
    .full      (lq_full),
    .empty     (lq_empty),
    .cmp_addr  (hz_addr[4:0]),
    .hit       (lq_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && sweep_cnt == 5'd31) begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sweep_cnt  <= '0;
      starve_cnt <= '0;
      wen        <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
    end else if (!run) begin
      wen       <= 1'b1;
      waddr     <= ADDR_W'(sweep_cnt);
      wdata     <= '0;
      sweep_cnt <= sweep_cnt + 1'b1;
    end else begin
      if (alu_wr) begin
        wen   <= 1'b1;
        waddr <= alu_addr;
        wdata <= alu_data;
      end else if (lq_pop) begin
        wen   <= 1'b1;
        waddr <= lq_head.addr;
        wdata <= lq_head.data;
      end else begin
        wen <= 1'b0;
      end
      // Reaching the limit forces alu_ready low, so the counter never runs past it.
      if (lq_pop || lq_count == '0) begin
        starve_cnt <= '0;
      end else begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_picosoc_regs_wb.sv
// tb/tb_picosoc_regs_wb.sv - directed self-checking bench for picosoc_regs_wb
module tb_picosoc_regs_wb;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [5:0]  alu_addr;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;
  logic [5:0]  hz_addr;
  logic        hz_pending;
  logic        init_busy;
  logic        wen;
  logic [5:0]  waddr;
  logic [31:0] wdata;

  int n_checks = 0;
  int n_pass   = 0;

  picosoc_regs_wb dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .hz_addr   (hz_addr),
    .hz_pending(hz_pending),
    .init_busy (init_busy),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic hz_check(input string tag, input logic [5:0] a, input logic exp);
    hz_addr = a;
    #1;
    check(tag, {31'd0, hz_pending}, {31'd0, exp});
  endtask

  task automatic sweep();
    for (int i = 0; i < 32; i++) begin
      tick();
      check("sweep_wen", {31'd0, wen}, 32'd1);
      check("sweep_waddr", {26'd0, waddr}, i);
      check("sweep_wdata", wdata, 32'd0);
      check("sweep_busy", {31'd0, init_busy}, (i == 31) ? 32'd0 : 32'd1);
      check("sweep_alu_ready", {31'd0, alu_ready}, (i == 31) ? 32'd1 : 32'd0);
    end
    tick();
    check("post_sweep_wen", {31'd0, wen}, 32'd0);
    check("post_sweep_ld_ready", {31'd0, ld_ready}, 32'd1);
  endtask

  task automatic expect_write(input string tag, input logic [5:0] a, input logic [31:0] d);
    check({tag, "_wen"}, {31'd0, wen}, 32'd1);
    check({tag, "_waddr"}, {26'd0, waddr}, {26'd0, a});
    check({tag, "_wdata"}, wdata, d);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b0;
    alu_valid = 1'b0;
    alu_addr  = '0;
    alu_data  = '0;
    ld_valid  = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    hz_addr   = '0;
    #1 reset = 1'b1;
    #2;
    check("rst_wen", {31'd0, wen}, 32'd0);
    check("rst_waddr", {26'd0, waddr}, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_busy", {31'd0, init_busy}, 32'd1);
    check("rst_hz", {31'd0, hz_pending}, 32'd1);
    check("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    tick();
    tick();
    reset = 1'b0;

    sweep();

    // ALU write to x5, then a discarded write to x0
    alu_valid = 1'b1; alu_addr = 6'd5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b1; alu_addr = 6'd0; alu_data = 32'h1234;
    expect_write("alu_x5", 6'd5, 32'hDEADBEEF);
    tick();
    alu_valid = 1'b0;
    check("alu_x0_wen", {31'd0, wen}, 32'd0);
    check("alu_x0_hold", {26'd0, waddr}, 32'd5);

    // Two loads while the ALU keeps the port busy with x9
    hz_check("hz_empty", 6'd3, 1'b0);
    ld_valid = 1'b1; ld_addr = 6'd3; ld_data = 32'h11;
    alu_valid = 1'b1; alu_addr = 6'd9; alu_data = 32'h99;
    tick();
    expect_write("alu_x9a", 6'd9, 32'h99);
    check("ld_ready_1", {31'd0, ld_ready}, 32'd1);
    hz_check("hz_x3", 6'd3, 1'b1);
    hz_check("hz_x0", 6'd0, 1'b0);
    hz_check("hz_x3_bit5", 6'd35, 1'b1);
    hz_check("hz_x4_absent", 6'd4, 1'b0);
    ld_addr = 6'd4; ld_data = 32'h22; alu_data = 32'h9A;
    tick();
    expect_write("alu_x9b", 6'd9, 32'h9A);
    check("ld_ready_full", {31'd0, ld_ready}, 32'd0);
    ld_valid = 1'b0; alu_valid = 1'b0;
    tick();
    expect_write("ld_x3", 6'd3, 32'h11);
    check("ld_ready_after_pop", {31'd0, ld_ready}, 32'd1);
    tick();
    expect_write("ld_x4", 6'd4, 32'h22);
    hz_check("hz_drained", 6'd4, 1'b0);
    tick();
    check("idle_wen", {31'd0, wen}, 32'd0);

    // Starvation: one queued load against a continuous ALU stream to x7
    ld_valid = 1'b1; ld_addr = 6'd6; ld_data = 32'h66;
    alu_valid = 1'b1; alu_addr = 6'd7; alu_data = 32'h71;
    tick();
    ld_valid = 1'b0;
    expect_write("starve_e1", 6'd7, 32'h71);
    for (int k = 2; k <= 5; k++) begin
      alu_data = 32'h70 + k;
      tick();
      expect_write("starve_alu", 6'd7, 32'h70 + k);
      check("starve_alu_ready", {31'd0, alu_ready}, (k == 5) ? 32'd0 : 32'd1);
    end
    alu_data = 32'h76;
    tick();
    expect_write("starve_pop", 6'd6, 32'h66);
    check("starve_resume_ready", {31'd0, alu_ready}, 32'd1);
    tick();
    expect_write("starve_resume", 6'd7, 32'h76);
    alu_valid = 1'b0;
    tick();

    // Full queue with a third load waiting
    ld_valid = 1'b1; ld_addr = 6'd10; ld_data = 32'hA0;
    alu_valid = 1'b1; alu_addr = 6'd8; alu_data = 32'h80;
    tick();
    ld_addr = 6'd11; ld_data = 32'hA1;
    tick();
    check("full_ld_ready", {31'd0, ld_ready}, 32'd0);
    ld_addr = 6'd12; ld_data = 32'hA2;
    tick();
    check("full_blocked", {31'd0, ld_ready}, 32'd0);
    hz_check("full_hz_x12", 6'd12, 1'b0);
    alu_valid = 1'b0;
    tick();
    expect_write("full_pop10", 6'd10, 32'hA0);
    check("full_ready_again", {31'd0, ld_ready}, 32'd1);
    tick();
    ld_valid = 1'b0;
    expect_write("full_pop11", 6'd11, 32'hA1);
    check("pushpop_ready", {31'd0, ld_ready}, 32'd1);
    hz_check("pushpop_hz_x12", 6'd12, 1'b1);
    tick();
    expect_write("full_pop12", 6'd12, 32'hA2);
    hz_check("pushpop_hz_done", 6'd12, 1'b0);
    tick();
    check("full_idle", {31'd0, wen}, 32'd0);

    // Reset with two loads queued
    ld_valid = 1'b1; ld_addr = 6'd13; ld_data = 32'hB0;
    alu_valid = 1'b1; alu_addr = 6'd8; alu_data = 32'h81;
    tick();
    ld_addr = 6'd14; ld_data = 32'hB1;
    tick();
    check("pre_rst_full", {31'd0, ld_ready}, 32'd0);
    ld_valid = 1'b0; alu_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_wen", {31'd0, wen}, 32'd0);
    check("mid_rst_busy", {31'd0, init_busy}, 32'd1);
    check("mid_rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    sweep();
    hz_check("rst_lost_x13", 6'd13, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rst_no_stale_write", {31'd0, wen}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
